// File: rtl/conv_pkg.sv
// Shared types and geometry helpers for the convolution sequencer.
// The state enum is used by the FSM. The helper functions derive the image
// geometry from the line-buffer parameter P and the row count ROWS:
//   row_len : pixels per image row (P+1)
//   npix    : pixels per frame
//   nout    : valid 3x3 windows per frame
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FILL,
        READ,
        DRAIN,
        DONE
    } state_t;

    function automatic int row_len(input int p);
        return p + 1;
    endfunction

    function automatic int npix(input int p, input int rows);
        return (p + 1) * rows;
    endfunction

    function automatic int nout(input int p, input int rows);
        return (rows - 2) * (p - 1);
    endfunction

    localparam int P_DEF    = 5;
    localparam int ROWS_DEF = 6;
    localparam int ROW      = row_len(P_DEF);
    localparam int NPIX     = npix(P_DEF, ROWS_DEF);
    localparam int NOUT     = nout(P_DEF, ROWS_DEF);

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Bundle between the sequencer, the system side and the convolution datapath.
// Ports carried:
//   start, kernel_we, in_valid, full, out_ready : driven by system/datapath
//   in_ready, out_valid, busy, done             : handshake/status from controller
//   load, sh, selpix, sel0, init0,
//   wr_inram, rd_inram, pixadr[M-1:0]           : datapath controls from controller
// master = system/datapath side, slave = sequencer.
interface conv_seq_ctrl_if #(
    parameter int M = 6
);
    logic         start;
    logic         kernel_we;
    logic         in_valid;
    logic         in_ready;
    logic         full;
    logic         out_ready;
    logic         out_valid;
    logic         busy;
    logic         done;
    logic         load;
    logic         sh;
    logic         selpix;
    logic         sel0;
    logic         init0;
    logic         wr_inram;
    logic         rd_inram;
    logic [M-1:0] pixadr;

    modport master (
        output start, kernel_we, in_valid, full, out_ready,
        input  in_ready, out_valid, busy, done,
        input  load, sh, selpix, sel0, init0, wr_inram, rd_inram, pixadr
    );

    modport slave (
        input  start, kernel_we, in_valid, full, out_ready,
        output in_ready, out_valid, busy, done,
        output load, sh, selpix, sel0, init0, wr_inram, rd_inram, pixadr
    );
endinterface

// File: rtl/conv_addr_cnt.sv
// Pixel counter shared by the FILL and READ phases.
// Ports:
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear of k and col (priority over inc)
//   inc      : advance k by one, col wraps ROW-1 -> 0
//   k        : current pixel index (also the RAM address)
//   last     : k is the final pixel of the frame
//   win_ok   : shifting pixel k completes a valid 3x3 window
module conv_addr_cnt
    import conv_pkg::*;
#(
    parameter int M    = 6,
    parameter int P    = 5,
    parameter int ROWS = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [M-1:0] k,
    output logic         last,
    output logic         win_ok
);
    localparam int RL  = row_len(P);
    localparam int NP  = npix(P, ROWS);
    localparam int CW  = (RL > 2) ? $clog2(RL) : 2;

    // col mirrors k mod ROW so the window test needs no divider.
    logic [CW-1:0] col;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k   <= '0;
            col <= '0;
        end else if (clr) begin
            k   <= '0;
            col <= '0;
        end else if (inc) begin
            k   <= k + M'(1);
            col <= (col == CW'(RL - 1)) ? '0 : col + CW'(1);
        end
    end

    assign last   = (k == M'(NP - 1));
    // Two full rows plus two pixels must be in the chain, and the window
    // must not straddle a row end.
    assign win_ok = (k >= M'(2 * RL + 2)) && (col >= CW'(2));

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencing FSM for the 9-multiplier convolution datapath.
// Loads the image into pixel RAM, replays it through the tap chain and flags
// each valid 3x3 window result with out_valid/out_ready backpressure.
// Ports:
//   clk, rst : clock, async active-high reset
//   bus      : conv_seq_ctrl_if slave view (handshakes, status, datapath controls)
//
// state | meaning
// IDLE  | waiting for start; kernel_we passes straight to load
// CLEAR | one cycle, zero the tap chain, reset pixel counter
// FILL  | accept streamed pixels into RAM at addresses 0..NPIX-1
// READ  | replay RAM through the chain, one pixel per advancing cycle
// DRAIN | all pixels shifted, wait for the last window to be taken
// DONE  | one-cycle done pulse
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int N    = 8,
    parameter int M    = 6,
    parameter int P    = 5,
    parameter int ROWS = 6
) (
    input  logic clk,
    input  logic rst,
    conv_seq_ctrl_if.slave bus
);
    if (N < 1 || npix(P, ROWS) > (1 << M)) begin : g_cfg_err
        $error("conv_seq_ctrl: image does not fit pixel RAM or N invalid");
    end

    state_t       state, state_d;
    logic         ov_q, ov_d;
    logic         cnt_clr, cnt_inc;
    logic [M-1:0] k;
    logic         last, win_ok;
    logic         accept, adv;

    conv_addr_cnt #(
        .M   (M),
        .P   (P),
        .ROWS(ROWS)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .k     (k),
        .last  (last),
        .win_ok(win_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ov_q  <= 1'b0;
        end else begin
            state <= state_d;
            ov_q  <= ov_d;
        end
    end

    assign accept = bus.in_valid && !bus.full;
    // A presented but unaccepted window freezes the chain.
    assign adv    = !(ov_q && !bus.out_ready);

    always_comb begin
        state_d      = state;
        ov_d         = ov_q;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        bus.load     = 1'b0;
        bus.sh       = 1'b0;
        bus.selpix   = 1'b0;
        bus.sel0     = 1'b0;
        bus.init0    = 1'b0;
        bus.wr_inram = 1'b0;
        bus.rd_inram = 1'b0;
        bus.in_ready = 1'b0;
        bus.done     = 1'b0;
        bus.pixadr   = '0;
        case (state)
            IDLE: begin
                bus.load = bus.kernel_we;
                if (bus.start) state_d = CLEAR;
            end
            CLEAR: begin
                bus.init0 = 1'b1;
                bus.sel0  = 1'b1;
                cnt_clr   = 1'b1;
                ov_d      = 1'b0;
                state_d   = FILL;
            end
            FILL: begin
                bus.in_ready = !bus.full;
                bus.pixadr   = k;
                if (accept) begin
                    bus.wr_inram = 1'b1;
                    if (last) begin
                        cnt_clr = 1'b1;
                        state_d = READ;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            READ: begin
                bus.selpix = 1'b1;
                bus.pixadr = k;
                if (adv) begin
                    bus.rd_inram = 1'b1;
                    bus.sh       = 1'b1;
                    ov_d         = win_ok;
                    if (last) begin
                        cnt_clr = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (adv) begin
                    ov_d    = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.out_valid = ov_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
module tb_conv_seq_ctrl;
    localparam int N     = 8;
    localparam int M     = 6;
    localparam int P     = 5;
    localparam int ROWS  = 6;
    localparam int ROW   = P + 1;
    localparam int NPIX  = ROW * ROWS;
    localparam int NOUT  = (ROWS - 2) * (ROW - 2);
    localparam int CHAIN = 2 * P + 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_seq_ctrl_if #(.M(M)) bus ();

    conv_seq_ctrl #(
        .N   (N),
        .M   (M),
        .P   (P),
        .ROWS(ROWS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Datapath model: pixel RAM, tap chain, identity kernel (result = centre tap).
    logic [N-1:0] datain;
    logic [N-1:0] ram [0:(1<<M)-1];
    logic [N-1:0] w   [1:CHAIN];
    logic [N-1:0] result;
    logic         kernel_ok;

    always @(posedge clk) begin
        if (bus.wr_inram) ram[bus.pixadr] <= datain;
        if (bus.load) kernel_ok <= 1'b1;
        if (bus.init0) begin
            for (int j = 1; j <= CHAIN; j++) w[j] <= '0;
        end else if (bus.sh) begin
            for (int j = CHAIN; j > 1; j--) w[j] <= w[j-1];
            w[1] <= bus.sel0 ? '0 : (bus.selpix ? ram[bus.pixadr] : '0);
        end
    end
    assign result = w[ROW+2];

    logic [10:0] ctrl;
    assign ctrl = {bus.load, bus.sh, bus.selpix, bus.sel0, bus.init0, bus.wr_inram,
                   bus.rd_inram, bus.in_ready, bus.out_valid, bus.busy, bus.done};

    int checks = 0;
    int errors = 0;
    int wr_count, ov_count, done_count;
    logic         last_sh;
    logic [M-1:0] last_k;
    logic [N-1:0] exp_res [0:NOUT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Negedge monitor: write addresses, window values, validity rule, done pulses.
    always @(negedge clk) begin
        if (rst) begin
            last_sh = 1'b0;
        end else begin
            if (last_sh)
                chk("ov_rule", 32'(bus.out_valid),
                    32'((int'(last_k) >= 2*ROW+2) && (int'(last_k) % ROW >= 2)));
            if (bus.wr_inram) begin
                chk("wr_adr", 32'(bus.pixadr), 32'(wr_count));
                wr_count++;
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("window_in_range", 32'(ov_count < NOUT), 32'd1);
                if (ov_count < NOUT) chk("win_result", 32'(result), 32'(exp_res[ov_count]));
                if (ov_count == 0) chk("kernel_loaded", 32'(kernel_ok), 32'd1);
                ov_count++;
            end
            if (bus.done) done_count++;
            last_sh = bus.sh;
            last_k  = bus.pixadr;
        end
    end

    task automatic clear_counts();
        wr_count   = 0;
        ov_count   = 0;
        done_count = 0;
    endtask

    task automatic start_frame(input bit with_kernel);
        bus.start     = 1'b1;
        bus.kernel_we = with_kernel;
        @(negedge clk);
        chk("start_ctrl", 32'(ctrl), with_kernel ? 32'h400 : 32'h000);
        step();
        bus.start     = 1'b0;
        bus.kernel_we = 1'b0;
        @(negedge clk);
        chk("clear_ctrl", 32'(ctrl), 32'h0C2);
        step();
    endtask

    task automatic fill(input bit gaps, input int full_at);
        int nxt = 0;
        int cyc = 0;
        bit acc;
        while (nxt < NPIX && cyc < 400) begin
            bus.in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            bus.full     = (full_at >= 0 && cyc >= full_at && cyc < full_at + 3);
            datain       = N'(nxt);
            @(negedge clk);
            chk("fill_in_ready", 32'(bus.in_ready), 32'(!bus.full));
            if (bus.full) chk("full_no_write", 32'(bus.wr_inram), 32'd0);
            acc = bus.in_valid && bus.in_ready;
            step();
            if (acc) nxt++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.full     = 1'b0;
        chk("fill_count", 32'(nxt), 32'(NPIX));
    endtask

    task automatic read_out(input int stall_at, input int stall_len);
        int cyc = 0;
        int first = -1;
        bit stalled = 1'b0;
        logic [M-1:0] hold_adr;
        logic [N-1:0] hold_res;
        bus.out_ready = 1'b1;
        while (!bus.done && cyc < 400) begin
            if (first < 0 && bus.out_valid) first = cyc;
            if (!stalled && stall_at >= 0 && bus.out_valid && ov_count == stall_at) begin
                stalled       = 1'b1;
                hold_adr      = bus.pixadr;
                hold_res      = result;
                bus.out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    chk("stall_sh", 32'(bus.sh), 32'd0);
                    chk("stall_rd", 32'(bus.rd_inram), 32'd0);
                    chk("stall_valid", 32'(bus.out_valid), 32'd1);
                    chk("stall_adr", 32'(bus.pixadr), 32'(hold_adr));
                    chk("stall_res", 32'(result), 32'(hold_res));
                    step();
                    cyc++;
                end
                bus.out_ready = 1'b1;
            end
            step();
            cyc++;
        end
        chk("frame_done_seen", 32'(bus.done), 32'd1);
        chk("first_valid_latency", 32'(first), 32'(2*ROW+3));
        if (stall_at >= 0) chk("stall_applied", 32'(stalled), 32'd1);
    endtask

    task automatic run_frame(input bit gaps, input int full_at, input int stall_at,
                             input int stall_len, input bit with_kernel);
        clear_counts();
        start_frame(with_kernel);
        fill(gaps, full_at);
        read_out(stall_at, stall_len);
        step();
        @(negedge clk);
        chk("post_frame_ctrl", 32'(ctrl), 32'd0);
        chk("write_total", 32'(wr_count), 32'(NPIX));
        chk("window_total", 32'(ov_count), 32'(NOUT));
        chk("done_pulses", 32'(done_count), 32'd1);
        step();
    endtask

    typedef struct {
        logic        kwe;
        logic        iv;
        logic        fl;
        logic        ordy;
        logic [10:0] exp_ctrl;
    } idle_vec_t;

    idle_vec_t tbl [6];

    initial begin
        exp_res = '{8'd7, 8'd8, 8'd9, 8'd10, 8'd13, 8'd14, 8'd15, 8'd16,
                    8'd19, 8'd20, 8'd21, 8'd22, 8'd25, 8'd26, 8'd27, 8'd28};
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 11'h000};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 11'h400};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 11'h400};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 11'h000};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 11'h000};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 11'h400};

        kernel_ok     = 1'b0;
        last_sh       = 1'b0;
        last_k        = '0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.kernel_we = 1'b0;
        bus.in_valid  = 1'b0;
        bus.full      = 1'b0;
        bus.out_ready = 1'b0;
        datain        = '0;
        clear_counts();

        step();
        @(negedge clk);
        chk("reset_ctrl", 32'(ctrl), 32'd0);
        chk("reset_pixadr", 32'(bus.pixadr), 32'd0);
        step();
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            bus.kernel_we = tbl[i].kwe;
            bus.in_valid  = tbl[i].iv;
            bus.full      = tbl[i].fl;
            bus.out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("idle_vec%0d", i), 32'(ctrl), 32'(tbl[i].exp_ctrl));
            chk($sformatf("idle_pixadr%0d", i), 32'(bus.pixadr), 32'd0);
            step();
        end
        bus.kernel_we = 1'b0;
        bus.in_valid  = 1'b0;
        bus.full      = 1'b0;
        bus.out_ready = 1'b0;
        kernel_ok     = 1'b0;
        step();

        // Frame A: back-to-back pixels, kernel loaded together with start.
        run_frame(1'b0, -1, -1, 0, 1'b1);

        // Frame B: input gaps, full for 3 cycles, 5-cycle stall at 3rd window.
        run_frame(1'b1, 10, 2, 5, 1'b0);

        // Reset mid-READ: immediate abort, no done pulse.
        clear_counts();
        start_frame(1'b0);
        fill(1'b0, -1);
        bus.out_ready = 1'b1;
        repeat (20) step();
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ctrl", 32'(ctrl), 32'd0);
        chk("rst_mid_pixadr", 32'(bus.pixadr), 32'd0);
        step();
        rst = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rst_mid_idle", 32'(ctrl), 32'd0);
        chk("rst_mid_no_done", 32'(done_count), 32'd0);
        step();

        // Frame C: clean frame after the abort.
        run_frame(1'b0, -1, -1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
